mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access stage placed directly after the EX/MEM pipeline register. It consumes that register's outputs.
- Drives data-memory and IO accesses: byte-lane store masks, load extraction and sign extension.
- Stalls upstream while a synchronous-RAM load is in flight.
- Registers the write-back bundle for the WB stage.

Parameters:
- ADDR_W, 14: byte-address width of data memory. Word address = ALUResult_i[ADDR_W-1:2].
- LOAD_LAT, 1: data-memory read latency in cycles (1..3).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high (1 = reset), despite the name.
- RegWrite_i  in  1  instruction writes rd.
- MemRead_i  in  1  data-memory load.
- MemWrite_i  in  1  data-memory store.
- MemOrIoToReg_i  in  1  0: write-back ALUResult_i; 1: write-back loaded data.
- IoRead_i  in  1  IO load.
- IoWrite_i  in  1  IO store.
- ByteOrWord_i  in  2  access size: 00 word, 01 byte, 10 halfword, 11 treated as word.
- ALUResult_i  in  32  effective address / ALU value.
- rdata2_i  in  32  store data.
- rd_i  in  5  destination register.
- mem_en_o  out  1  data-memory enable.
- mem_we_o  out  4  byte write enables.
- mem_addr_o  out  ADDR_W-2  word address.
- mem_wdata_o  out  32  lane-replicated store data.
- mem_rdata_i  in  32  memory read data, valid LOAD_LAT cycles after the enabled edge.
- io_re_o  out  1  IO read strobe.
- io_we_o  out  1  IO write strobe.
- io_wdata_o  out  32  IO write data.
- io_rdata_i  in  32  IO read data, combinational.
- stall_o  out  1  upstream must hold its inputs this cycle.
- misalign_o  out  1  registered one-cycle pulse on a misaligned access.
- RegWrite_o  out  1  write-back enable.
- rd_o  out  5  write-back register.
- wdata_o  out  32  write-back data.

Behaviour:
- FSM states: IDLE, LOAD_WAIT. Down-counter cnt is 2 bits.
- Reset (asynchronous): state=IDLE, cnt=0. RegWrite_o, rd_o, wdata_o, misalign_o = 0. Combinational outputs follow from IDLE with no request.
- Reset during LOAD_WAIT aborts the load: no write-back, stall_o drops immediately.
- Misaligned access:
  - Defined as word access with ALUResult_i[1:0]!=0, or halfword with ALUResult_i[0]=1.
  - Suppresses mem_we_o/io_we_o and the load, forces RegWrite_o=0, pulses misalign_o for one cycle.
- IO priority: IoRead_i/IoWrite_i override MemRead_i/MemWrite_i; no memory access is issued.
- Store (IDLE, MemWrite_i, aligned): same cycle mem_en_o=1.
  - Byte: mem_wdata_o = {4{rdata2_i[7:0]}}, mem_we_o = 1<<ALUResult_i[1:0].
  - Half: mem_wdata_o = {2{rdata2_i[15:0]}}, mem_we_o = 0011 or 1100.
  - Word: mem_wdata_o = rdata2_i, mem_we_o = 1111.
  - No stall.
- IO store: io_we_o=1 for that cycle, io_wdata_o=rdata2_i. No stall.
- IO load: io_re_o=1. io_rdata_i is extracted per size and registered at the same edge. Latency 1, no stall.
- Memory load, cycle T (IDLE, MemRead_i, aligned): mem_en_o=1, stall_o=1, next state LOAD_WAIT, cnt=LOAD_LAT-1. Write-back registers load a bubble (RegWrite_o=0).
- LOAD_WAIT:
  - stall_o = (cnt!=0), mem_addr_o held, cnt decrements.
  - When cnt==0: extract from mem_rdata_i using the byte offset of the held address, register the write-back (RegWrite_o=RegWrite_i), return to IDLE.
  - Total latency LOAD_LAT+1 cycles. Upstream advances at the edge ending the last wait cycle.
- Extraction: byte lane = addr[1:0]; half lane = addr[1]. Byte and half results are sign-extended to 32 bits.
- Non-memory instruction: wdata_o = ALUResult_i, RegWrite_o = RegWrite_i, 1-cycle latency.
- MemOrIoToReg_i=0 with MemRead_i=1: the load is still performed, but wdata_o = ALUResult_i.
- Back-to-back loads: the second load is accepted in the IDLE cycle immediately after LOAD_WAIT ends; no dead cycle.

Optional Feature:
- Macro MEM_FWD_EN.
- When defined: adds outputs fwd_valid_o (1), fwd_rd_o (5), fwd_data_o (32). These combinationally expose the result about to be registered, for forwarding to EX. fwd_valid_o=0 while stall_o=1, for misaligned accesses, and when rd_i=0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Word store: ALUResult_i=0x10, rdata2_i=0xDEADBEEF, ByteOrWord_i=00 -> mem_we_o=1111, mem_addr_o=4, mem_wdata_o=0xDEADBEEF, stall_o=0.
- Byte load, LOAD_LAT=1: addr 0x13, mem_rdata_i=0x80FF1234 -> stall_o high 1 cycle; after 2 cycles wdata_o=0xFFFFFF80, RegWrite_o=1, rd_o=rd_i.
- LOAD_LAT=3 halfword load: addr 0x2, mem_rdata_i=0x7ABC0000 -> stall_o high 3 cycles; wdata_o=0x00007ABC at cycle 4.
- Misaligned word store at 0x6 -> mem_we_o=0000, misalign_o pulses 1 cycle, RegWrite_o=0.
- IO read with MemRead_i also set: io_rdata_i=0x5A -> mem_en_o=0, io_re_o=1, no stall, wdata_o=0x5A next cycle.
- Assert rst_n in the middle of LOAD_WAIT -> stall_o=0 immediately, RegWrite_o=0, next load starts from IDLE correctly.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: store byte lanes, load extraction, load-wait stall and write-back register.
// Optional forwarding outputs (fwd_*) are built only when MEM_FWD_EN is defined.
module mem_access_stage #(
  parameter int ADDR_W   = 14,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemOrIoToReg_i,
  input  logic              IoRead_i,
  input  logic              IoWrite_i,
  input  logic [1:0]        ByteOrWord_i,
  input  logic [31:0]       ALUResult_i,
  input  logic [31:0]       rdata2_i,
  input  logic [4:0]        rd_i,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              io_re_o,
  output logic              io_we_o,
  output logic [31:0]       io_wdata_o,
  input  logic [31:0]       io_rdata_i,
  output logic              stall_o,
  output logic              misalign_o,
`ifdef MEM_FWD_EN
  output logic              fwd_valid_o,
  output logic [4:0]        fwd_rd_o,
  output logic [31:0]       fwd_data_o,
`endif
  output logic              RegWrite_o,
  output logic [4:0]        rd_o,
  output logic [31:0]       wdata_o
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  state_t            state, state_next;
  logic [1:0]        cnt, cnt_next;

  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ld_size;
  logic [4:0]        ld_rd;
  logic              ld_regwrite;
  logic              ld_to_reg;
  logic [31:0]       ld_alu;

  logic              size_byte, size_half, size_word;
  logic              any_access, io_sel, misaligned, accept;
  logic              do_load, do_store, do_io_rd, do_io_wr;
  logic              waiting, last_wait;
  logic [3:0]        lane_mask;

  logic              wb_we_next;
  logic [4:0]        wb_rd_next;
  logic [31:0]       wb_data_next;

  // Byte lane picks addr[1:0], half lane picks addr[1]; narrow results are sign-extended.
  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] off,
                                          input logic [1:0] size);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (size)
      2'b01:   extract = {{24{b[7]}}, b};
      2'b10:   extract = {{16{h[15]}}, h};
      default: extract = d;
    endcase
  endfunction

  // Request decode; nothing is accepted outside IDLE or while reset is asserted.
  always_comb begin
    size_byte  = (ByteOrWord_i == 2'b01);
    size_half  = (ByteOrWord_i == 2'b10);
    size_word  = !size_byte && !size_half;
    any_access = MemRead_i || MemWrite_i || IoRead_i || IoWrite_i;
    io_sel     = IoRead_i || IoWrite_i;
    misaligned = any_access && ((size_word && (ALUResult_i[1:0] != 2'b00)) ||
                                (size_half && ALUResult_i[0]));
    accept     = (state == IDLE) && !rst_n;
    do_load    = accept && MemRead_i && !io_sel && !misaligned;
    do_store   = accept && MemWrite_i && !io_sel && !misaligned;
    do_io_rd   = accept && IoRead_i && !misaligned;
    do_io_wr   = accept && IoWrite_i && !misaligned;
    waiting    = (state == LOAD_WAIT) && !rst_n;
    last_wait  = waiting && (cnt == 2'd0);
    if (size_byte)
      lane_mask = 4'b0001 << ALUResult_i[1:0];
    else if (size_half)
      lane_mask = ALUResult_i[1] ? 4'b1100 : 4'b0011;
    else
      lane_mask = 4'b1111;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The load's context is captured so the wait phase never depends on upstream holding.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ld_addr     <= '0;
      ld_size     <= 2'b00;
      ld_rd       <= 5'd0;
      ld_regwrite <= 1'b0;
      ld_to_reg   <= 1'b0;
      ld_alu      <= 32'd0;
    end else if (do_load) begin
      ld_addr     <= ALUResult_i[ADDR_W-1:0];
      ld_size     <= ByteOrWord_i;
      ld_rd       <= rd_i;
      ld_regwrite <= RegWrite_i;
      ld_to_reg   <= MemOrIoToReg_i;
      ld_alu      <= ALUResult_i;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (do_load) begin
          state_next = LOAD_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      LOAD_WAIT: begin
        if (cnt == 2'd0)
          state_next = IDLE;
        else
          cnt_next = cnt - 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Enable stays high while waiting so the RAM output remains valid for the held address.
  always_comb begin
    mem_en_o    = do_load || do_store || waiting;
    mem_we_o    = do_store ? lane_mask : 4'b0000;
    mem_addr_o  = (state == LOAD_WAIT) ? ld_addr[ADDR_W-1:2] : ALUResult_i[ADDR_W-1:2];
    mem_wdata_o = size_byte ? {4{rdata2_i[7:0]}} :
                  size_half ? {2{rdata2_i[15:0]}} : rdata2_i;
    io_re_o     = do_io_rd;
    io_we_o     = do_io_wr;
    io_wdata_o  = rdata2_i;
    stall_o     = do_load || (waiting && (cnt != 2'd0));
  end

  always_comb begin
    wb_we_next   = 1'b0;
    wb_rd_next   = rd_i;
    wb_data_next = ALUResult_i;
    if (state == LOAD_WAIT) begin
      wb_rd_next   = ld_rd;
      wb_data_next = ld_alu;
      if (last_wait) begin
        wb_we_next = ld_regwrite;
        if (ld_to_reg)
          wb_data_next = extract(mem_rdata_i, ld_addr[1:0], ld_size);
      end
    end else if (!misaligned && !do_load) begin
      wb_we_next = RegWrite_i;
      if (IoRead_i && MemOrIoToReg_i)
        wb_data_next = extract(io_rdata_i, ALUResult_i[1:0], ByteOrWord_i);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      RegWrite_o <= 1'b0;
      rd_o       <= 5'd0;
      wdata_o    <= 32'd0;
      misalign_o <= 1'b0;
    end else begin
      RegWrite_o <= wb_we_next;
      rd_o       <= wb_rd_next;
      wdata_o    <= wb_data_next;
      misalign_o <= accept && misaligned;
    end
  end

`ifdef MEM_FWD_EN
  assign fwd_valid_o = wb_we_next && !stall_o && !rst_n && (wb_rd_next != 5'd0);
  assign fwd_rd_o    = wb_rd_next;
  assign fwd_data_o  = wb_data_next;
`endif

endmodule
